mul_error_accum: RTL and testbench

MUL_ERROR_ACCUM -- requirements
Module: mul_error_accum

---
 rtl/mul_error_accum.sv | 210 +++++++++++++++++++++
 tb/tb_mul_error_accum.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_error_accum.sv
// mul_error_accum
// Error statistics collector for a 4x4 approximate multiplier. Each accepted
// sample (a, b, result) is compared against the exact product; the block
// accumulates sample count, error count, max/sum of error distance and,
// optionally, the sum of relative errors in unsigned Q8.8.
//
// Optional feature macro: MUL_ERR_REL_EN
//   defined   -> DIV state with a bit-serial restoring divider computing
//                floor(ed*256/exact), accumulated into sum_rel.
//   undefined -> no divider, every sample goes straight to ACC, sum_rel = 0.
//
// All counters and sums saturate at all-ones. clr clears synchronously and
// wins over an accept; rst_n clears asynchronously.

module mul_error_accum #(
  parameter int SUM_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic [7:0]       result,
  output logic             busy,
  output logic [8:0]       sample_cnt,
  output logic [8:0]       err_cnt,
  output logic [7:0]       max_ed,
  output logic [15:0]      sum_ed,
  output logic [SUM_W-1:0] sum_rel
);

`ifdef MUL_ERR_REL_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    ACC  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd2
  } state_t;
`endif

  state_t      state_reg;
  logic [7:0]  ed_reg;
  logic [8:0]  sample_cnt_reg;
  logic [8:0]  err_cnt_reg;
  logic [7:0]  max_ed_reg;
  logic [15:0] sum_ed_reg;

  logic [7:0]  exact_calc;
  logic [7:0]  ed_calc;
  logic        accept;

  logic [8:0]  sample_cnt_next;
  logic [8:0]  err_cnt_next;
  logic [7:0]  max_ed_next;
  logic [16:0] sum_ed_wide;
  logic [15:0] sum_ed_next;

`ifdef MUL_ERR_REL_EN
  // Divider state: quot_reg starts as the dividend {ed, 8'h00} and has
  // quotient bits shifted in from the right, one per DIV cycle.
  logic [7:0]       exact_reg;
  logic [15:0]      quot_reg;
  logic [7:0]       rem_reg;
  logic [3:0]       div_cnt_reg;
  logic [SUM_W-1:0] sum_rel_reg;

  logic [8:0]       rem_shift;
  logic [7:0]       rem_sub;
  logic             div_ge;
  logic [7:0]       rem_next;
  logic [SUM_W:0]   sum_rel_wide;
  logic [SUM_W-1:0] sum_rel_next;
`endif

  // Exact product and absolute error distance of the offered sample.
  always_comb begin
    exact_calc = {4'd0, a} * {4'd0, b};
    if (result >= exact_calc) begin
      ed_calc = result - exact_calc;
    end else begin
      ed_calc = exact_calc - result;
    end
  end

  // rst_n gates in_ready so it reads 0 for the whole reset interval.
  assign in_ready = (state_reg == IDLE) && !clr && rst_n;
  assign accept   = in_valid && in_ready;
  assign busy     = (state_reg != IDLE);

  // Saturating next values for the accumulators, consumed in ACC.
  always_comb begin
    sample_cnt_next = (&sample_cnt_reg) ? sample_cnt_reg : sample_cnt_reg + 9'd1;
    if ((ed_reg != 8'd0) && !(&err_cnt_reg)) begin
      err_cnt_next = err_cnt_reg + 9'd1;
    end else begin
      err_cnt_next = err_cnt_reg;
    end
    sum_ed_wide = {1'b0, sum_ed_reg} + {9'd0, ed_reg};
    sum_ed_next = sum_ed_wide[16] ? 16'hFFFF : sum_ed_wide[15:0];
    max_ed_next = (ed_reg > max_ed_reg) ? ed_reg : max_ed_reg;
  end

`ifdef MUL_ERR_REL_EN
  // One restoring-division step plus saturating relative-error sum.
  always_comb begin
    rem_shift = {rem_reg, quot_reg[15]};
    div_ge    = (rem_shift >= {1'b0, exact_reg});
    // The true difference is below exact (<= 255), so 8 bits suffice.
    rem_sub   = rem_shift[7:0] - exact_reg;
    rem_next  = div_ge ? rem_sub : rem_shift[7:0];
    sum_rel_wide = {1'b0, sum_rel_reg} + {{(SUM_W-15){1'b0}}, quot_reg};
    sum_rel_next = sum_rel_wide[SUM_W] ? {SUM_W{1'b1}} : sum_rel_wide[SUM_W-1:0];
  end

  assign sum_rel = sum_rel_reg;
`else
  assign sum_rel = '0;
`endif

  assign sample_cnt = sample_cnt_reg;
  assign err_cnt    = err_cnt_reg;
  assign max_ed     = max_ed_reg;
  assign sum_ed     = sum_ed_reg;

  // Control FSM and accumulators; clr aborts any sample and zeroes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      ed_reg         <= 8'd0;
      sample_cnt_reg <= 9'd0;
      err_cnt_reg    <= 9'd0;
      max_ed_reg     <= 8'd0;
      sum_ed_reg     <= 16'd0;
`ifdef MUL_ERR_REL_EN
      exact_reg      <= 8'd0;
      quot_reg       <= 16'd0;
      rem_reg        <= 8'd0;
      div_cnt_reg    <= 4'd0;
      sum_rel_reg    <= '0;
`endif
    end else if (clr) begin
      state_reg      <= IDLE;
      ed_reg         <= 8'd0;
      sample_cnt_reg <= 9'd0;
      err_cnt_reg    <= 9'd0;
      max_ed_reg     <= 8'd0;
      sum_ed_reg     <= 16'd0;
`ifdef MUL_ERR_REL_EN
      exact_reg      <= 8'd0;
      quot_reg       <= 16'd0;
      rem_reg        <= 8'd0;
      div_cnt_reg    <= 4'd0;
      sum_rel_reg    <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            ed_reg <= ed_calc;
`ifdef MUL_ERR_REL_EN
            // Only a nonzero error against a nonzero product needs dividing.
            if ((exact_calc != 8'd0) && (ed_calc != 8'd0)) begin
              exact_reg   <= exact_calc;
              quot_reg    <= {ed_calc, 8'h00};
              rem_reg     <= 8'd0;
              div_cnt_reg <= 4'd0;
              state_reg   <= DIV;
            end else begin
              quot_reg    <= 16'd0;
              state_reg   <= ACC;
            end
`else
            state_reg <= ACC;
`endif
          end
        end
`ifdef MUL_ERR_REL_EN
        DIV: begin
          quot_reg    <= {quot_reg[14:0], div_ge};
          rem_reg     <= rem_next;
          div_cnt_reg <= div_cnt_reg + 4'd1;
          if (div_cnt_reg == 4'd15) begin
            state_reg <= ACC;
          end
        end
`endif
        ACC: begin
          sample_cnt_reg <= sample_cnt_next;
          err_cnt_reg    <= err_cnt_next;
          max_ed_reg     <= max_ed_next;
          sum_ed_reg     <= sum_ed_next;
`ifdef MUL_ERR_REL_EN
          sum_rel_reg    <= sum_rel_next;
`endif
          state_reg      <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_error_accum.sv
// Self-checking bench for mul_error_accum: table of directed samples,
// exhaustive exact sweep, clr/reset aborts and saturation, all scored
// against a queue of expected accumulator snapshots.
`timescale 1ns/1ps

module tb_mul_error_accum;

  localparam int SUM_W = 24;
`ifdef MUL_ERR_REL_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif
  localparam longint SR_MAX = (64'd1 << SUM_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       a;
  logic [3:0]       b;
  logic [7:0]       result;
  logic             busy;
  logic [8:0]       sample_cnt;
  logic [8:0]       err_cnt;
  logic [7:0]       max_ed;
  logic [15:0]      sum_ed;
  logic [SUM_W-1:0] sum_rel;

  always #5 clk = ~clk;

  mul_error_accum #(.SUM_W(SUM_W)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .result(result), .busy(busy),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt), .max_ed(max_ed),
    .sum_ed(sum_ed), .sum_rel(sum_rel)
  );

  typedef struct {
    longint sc;
    longint ec;
    longint me;
    longint se;
    longint sr;
    int     blen;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] r;
    int         ed;
    int         q;
    bit         div;
  } vec_t;

  exp_t   sb_q[$];
  vec_t   vecs[12];
  int     n_cmp = 0;
  int     n_err = 0;
  bit     mon_en = 1'b0;
  longint m_sc, m_ec, m_me, m_se, m_sr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_sc = 0; m_ec = 0; m_me = 0; m_se = 0; m_sr = 0;
  endtask

  // Update the reference accumulators for one accepted sample and queue the snapshot.
  task automatic model_push(input int ed, input int q, input int blen);
    exp_t e;
    m_sc = (m_sc + 1 > 511) ? 511 : m_sc + 1;
    if (ed != 0) m_ec = (m_ec + 1 > 511) ? 511 : m_ec + 1;
    m_se = (m_se + ed > 65535) ? 65535 : m_se + ed;
    if (REL) m_sr = (m_sr + q > SR_MAX) ? SR_MAX : m_sr + q;
    if (ed > m_me) m_me = ed;
    e.sc = m_sc; e.ec = m_ec; e.me = m_me; e.se = m_se; e.sr = m_sr; e.blen = blen;
    sb_q.push_back(e);
  endtask

  // Offer one sample, wait (bounded) for acceptance, optionally score it.
  task automatic send(input logic [3:0] ta, input logic [3:0] tb_, input logic [7:0] tr,
                      input int ed, input int q, input int blen, input bit push);
    int w;
    w = 0;
    @(negedge clk);
    a = ta; b = tb_; result = tr; in_valid = 1'b1;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    if (push) model_push(ed, q, blen);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 4'($urandom); b = 4'($urandom); result = 8'($urandom);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (sb_q.size() != 0) begin
      check("drain_timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sample_cnt"}, 64'(sample_cnt), 64'd0);
    check({tag, "_err_cnt"},    64'(err_cnt),    64'd0);
    check({tag, "_max_ed"},     64'(max_ed),     64'd0);
    check({tag, "_sum_ed"},     64'(sum_ed),     64'd0);
    check({tag, "_sum_rel"},    64'(sum_rel),    64'd0);
    check({tag, "_busy"},       64'(busy),       64'd0);
  endtask

  task automatic do_clr(input string tag);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready_during_clr"}, 64'(in_ready), 64'd0);
    check_zero(tag);
    clr = 1'b0;
    #1;
    check({tag, "_in_ready_after_clr"}, 64'(in_ready), 64'd1);
    model_reset();
  endtask

  // Monitor: a falling busy marks a completed ACC; compare with the oldest snapshot.
  initial begin
    logic prev_busy;
    int   busy_len;
    exp_t e;
    prev_busy = 1'b0;
    busy_len  = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || !mon_en) begin
        prev_busy = 1'b0;
        busy_len  = 0;
      end else begin
        if (busy) begin
          busy_len++;
          check("in_ready_low_while_busy", 64'(in_ready), 64'd0);
        end else if (prev_busy) begin
          if (sb_q.size() == 0) begin
            check("unexpected_completion", 64'd1, 64'd0);
          end else begin
            e = sb_q.pop_front();
            $display("txn: sc=%0d ec=%0d max=%0d sum_ed=%0d sum_rel=%0d busy=%0d",
                     sample_cnt, err_cnt, max_ed, sum_ed, sum_rel, busy_len);
            check("sample_cnt", 64'(sample_cnt), 64'(e.sc));
            check("err_cnt",    64'(err_cnt),    64'(e.ec));
            check("max_ed",     64'(max_ed),     64'(e.me));
            check("sum_ed",     64'(sum_ed),     64'(e.se));
            check("sum_rel",    64'(sum_rel),    64'(e.sr));
            check("busy_len",   64'(busy_len),   64'(e.blen));
          end
          busy_len = 0;
        end
        prev_busy = busy;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ta, tb_;
    // a, b, result, ed, floor(ed*256/exact), divide path
    vecs[0]  = '{4'd3,  4'd5, 8'd15,  0,    0, 1'b0};
    vecs[1]  = '{4'd3,  4'd5, 8'd12,  3,   51, 1'b1};
    vecs[2]  = '{4'd0,  4'd7, 8'd4,   4,    0, 1'b0};
    vecs[3]  = '{4'd15, 4'd15, 8'd0,  225, 256, 1'b1};
    vecs[4]  = '{4'd15, 4'd15, 8'd255, 30,  34, 1'b1};
    vecs[5]  = '{4'd1,  4'd1, 8'd0,   1,  256, 1'b1};
    vecs[6]  = '{4'd2,  4'd3, 8'd7,   1,   42, 1'b1};
    vecs[7]  = '{4'd7,  4'd9, 8'd100, 37, 150, 1'b1};
    vecs[8]  = '{4'd0,  4'd0, 8'd0,   0,    0, 1'b0};
    vecs[9]  = '{4'd15, 4'd1, 8'd255, 240, 4096, 1'b1};
    vecs[10] = '{4'd4,  4'd4, 8'd16,  0,    0, 1'b0};
    vecs[11] = '{4'd8,  4'd8, 8'd200, 136, 544, 1'b1};

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0;
    a = 4'd0; b = 4'd0; result = 8'd0;
    model_reset();

    // Reset state
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd0);
    check_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_reset", 64'(in_ready), 64'd1);
    mon_en = 1'b1;

    // Directed table, cumulative
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].ed, vecs[i].q,
           (REL && vecs[i].div) ? 17 : 1, 1'b1);
    end
    drain();

    // Exhaustive exact sweep
    do_clr("pre_sweep");
    for (int i = 0; i < 256; i++) begin
      ta  = 4'(i >> 4);
      tb_ = 4'(i);
      send(ta, tb_, 8'(ta * tb_), 0, 0, 1, 1'b1);
    end
    drain();
    check("sweep_sample_cnt", 64'(sample_cnt), 64'd256);
    check("sweep_sum_ed", 64'(sum_ed), 64'd0);

    // clr during the 5th DIV cycle (the single busy cycle without the divider)
    send(4'd3, 4'd5, 8'd12, 3, 51, REL ? 17 : 1, 1'b1);
    drain();
    mon_en = 1'b0;
    send(4'd3, 4'd5, 8'd12, 3, 51, 17, 1'b0);
    repeat (REL ? 5 : 1) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    check_zero("clr_abort");
    check("clr_abort_in_ready", 64'(in_ready), 64'd0);
    clr = 1'b0;
    #1;
    check("clr_abort_in_ready_after", 64'(in_ready), 64'd1);
    model_reset();
    repeat (20) @(negedge clk);
    check("clr_abort_no_late_acc", 64'(sample_cnt), 64'd0);
    mon_en = 1'b1;

    // rst_n pulse in the middle of a sample
    send(4'd2, 4'd3, 8'd7, 1, 42, REL ? 17 : 1, 1'b1);
    drain();
    mon_en = 1'b0;
    send(4'd15, 4'd15, 8'd0, 225, 256, 17, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_abort_in_ready", 64'(in_ready), 64'd0);
    check_zero("rst_abort");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_abort_in_ready_after", 64'(in_ready), 64'd1);
    model_reset();
    mon_en = 1'b1;
    send(4'd0, 4'd7, 8'd4, 4, 0, 1, 1'b1);
    drain();

    // Saturation: 600 samples of 15*15 reported as 0
    do_clr("pre_sat");
    for (int i = 0; i < 600; i++) begin
      send(4'd15, 4'd15, 8'd0, 225, 256, REL ? 17 : 1, 1'b1);
    end
    drain();
    check("sat_sample_cnt", 64'(sample_cnt), 64'd511);
    check("sat_err_cnt",    64'(err_cnt),    64'd511);
    check("sat_sum_ed",     64'(sum_ed),     64'd65535);
    check("sat_max_ed",     64'(max_ed),     64'd225);
    check("sat_sum_rel",    64'(sum_rel),    REL ? ((153600 > SR_MAX) ? 64'(SR_MAX) : 64'd153600) : 64'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
